// File: rtl/fuzzy_pkg.sv
// Shared fuzzy-controller types, widths and the defuzzifier state encoding.
// The products of weight and singleton are formed here so every stage agrees on width.
package fuzzy_pkg;

    typedef logic [15:0]        q15_t;
    typedef logic signed [15:0] sq15_t;

    localparam q15_t Q15_ONE   = 16'h8000;
    localparam int   DEN_W     = 18;
    localparam int   NUM_W     = 35;
    localparam int   DIV_ITERS = 16;

    typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} dfz_state_t;

    // unsigned weight times signed singleton, sign-extended to the accumulator width
    function automatic logic signed [NUM_W-1:0] wz_term(input q15_t w, input sq15_t z);
        logic signed [32:0] p;
        p = $signed({1'b0, w}) * z;
        return {{(NUM_W-33){p[32]}}, p};
    endfunction

endpackage

// File: rtl/defuzz4_wavg_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle, Q_W iterations.
// o_done/o_quot are valid combinationally during the final iteration cycle.
module udiv_seq #(
    parameter int DVD_W = 35,
    parameter int DVS_W = 18,
    parameter int Q_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quot
);

    localparam int SH_W  = DVS_W + Q_W - 1;
    localparam int CMP_W = (DVD_W > SH_W) ? DVD_W : SH_W;
    localparam int CNT_W = $clog2(Q_W);

    logic [DVD_W-1:0] r_rem;
    logic [SH_W-1:0]  r_dsh;
    logic [Q_W-1:0]   r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [CMP_W-1:0] w_rem_x;
    logic [CMP_W-1:0] w_dsh_x;
    logic [CMP_W-1:0] w_diff;
    logic             w_ge;

    assign w_rem_x = CMP_W'(r_rem);
    assign w_dsh_x = CMP_W'(r_dsh);
    assign w_ge    = (w_rem_x >= w_dsh_x);
    assign w_diff  = w_rem_x - w_dsh_x;

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CNT_W'(Q_W - 1));
    assign o_quot = {r_q[Q_W-2:0], w_ge};

    // load operands on start, then trial-subtract the shifted divisor each cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_dsh  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= i_dividend;
            r_dsh  <= {i_divisor, {(Q_W-1){1'b0}}};
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (w_ge) begin
                r_rem <= DVD_W'(w_diff);
            end
            r_dsh <= r_dsh >> 1;
            r_q   <= o_quot;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/defuzz4_wavg.sv
// Zero-order Sugeno defuzzifier: y = sum(w*Z)/sum(w) over four corner rules.
// Define DEFUZZ4_ROUND_EN for round-half-away-from-zero instead of truncation.
module defuzz4_wavg
    import fuzzy_pkg::*;
#(
    parameter sq15_t Z_NN      = -16'sh8000,
    parameter sq15_t Z_NP      = -16'sh4000,
    parameter sq15_t Z_PN      = 16'sh4000,
    parameter sq15_t Z_PP      = 16'sh7FFF,
    parameter sq15_t Y_DEFAULT = 16'sh0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] w_nn,
    input  logic [15:0] w_np,
    input  logic [15:0] w_pn,
    input  logic [15:0] w_pp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] y,
    output logic        div0
);

    dfz_state_t r_state;
    dfz_state_t w_next;

    q15_t  r_wnn, r_wnp, r_wpn, r_wpp;
    sq15_t r_y;
    logic  r_div0;
    logic  r_sign;

    logic signed [NUM_W-1:0] w_num;
    logic [DEN_W-1:0]        w_den;
    logic [NUM_W-1:0]        w_mag;
    logic [NUM_W-1:0]        w_dvd;
    logic                    w_accept;
    logic                    w_start;
    logic                    w_div_busy;
    logic                    w_div_done;
    logic [DIV_ITERS-1:0]    w_quot;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign y         = r_y;
    assign div0      = r_div0;
    assign w_accept  = in_valid && in_ready;

    assign w_num = wz_term(r_wnn, Z_NN) + wz_term(r_wnp, Z_NP)
                 + wz_term(r_wpn, Z_PN) + wz_term(r_wpp, Z_PP);
    assign w_den = {2'b00, r_wnn} + {2'b00, r_wnp}
                 + {2'b00, r_wpn} + {2'b00, r_wpp};
    assign w_mag = w_num[NUM_W-1] ? $unsigned(-w_num) : $unsigned(w_num);

`ifdef DEFUZZ4_ROUND_EN
    assign w_dvd = w_mag + NUM_W'(w_den >> 1);
`else
    assign w_dvd = w_mag;
`endif

    assign w_start = (r_state == SUM) && (w_den != '0);

    udiv_seq #(
        .DVD_W (NUM_W),
        .DVS_W (DEN_W),
        .Q_W   (DIV_ITERS)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_dividend (w_dvd),
        .i_divisor  (w_den),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quot     (w_quot)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state: a divider that is idle while in DIV can never finish, so leave
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = SUM;
            SUM:  w_next = (w_den == '0) ? DONE : DIV;
            DIV:  if (w_div_done || !w_div_busy) w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
        endcase
    end

    // weights are sampled only on the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wnn <= '0;
            r_wnp <= '0;
            r_wpn <= '0;
            r_wpp <= '0;
        end else if (w_accept) begin
            r_wnn <= w_nn;
            r_wnp <= w_np;
            r_wpn <= w_pn;
            r_wpp <= w_pp;
        end
    end

    // result registers: zero-den shortcut in SUM, signed quotient at end of DIV
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y    <= '0;
            r_div0 <= 1'b0;
            r_sign <= 1'b0;
        end else if (r_state == SUM) begin
            r_sign <= w_num[NUM_W-1];
            if (w_den == '0) begin
                r_y    <= Y_DEFAULT;
                r_div0 <= 1'b1;
            end else begin
                r_div0 <= 1'b0;
            end
        end else if ((r_state == DIV) && w_div_done) begin
            r_y <= r_sign ? -w_quot : w_quot;
        end
    end

endmodule

// File: tb/tb_defuzz4_wavg.sv
// Directed and randomized checks of defuzz4_wavg against an arithmetic model.
// Honors DEFUZZ4_ROUND_EN when the same define is given to the bench.
module tb_defuzz4_wavg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] w_nn, w_np, w_pn, w_pp;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        div0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    defuzz4_wavg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w_nn      (w_nn),
        .w_np      (w_np),
        .w_pn      (w_pn),
        .w_pp      (w_pp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .div0      (div0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // returns {div0, y} from the weighted-average definition
    function automatic logic [16:0] model(input logic [15:0] a, b, c, d);
        longint num, den, mag, q;
        num = -32768 * longint'(a) - 16384 * longint'(b)
            + 16384 * longint'(c) + 32767 * longint'(d);
        den = longint'(a) + longint'(b) + longint'(c) + longint'(d);
        if (den == 0) return {1'b1, 16'h0000};
        mag = (num < 0) ? -num : num;
`ifdef DEFUZZ4_ROUND_EN
        mag = mag + den / 2;
`endif
        q = mag / den;
        if (num < 0) q = -q;
        return {1'b0, 16'(q)};
    endfunction

    task automatic launch(input logic [15:0] a, b, c, d);
        w_nn = a; w_np = b; w_pn = c; w_pp = d;
        chk("in_ready_pre", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        w_nn = 16'($urandom); w_np = 16'($urandom);
        w_pn = 16'($urandom); w_pp = 16'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drain_ovalid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [16:0] exp;
        logic [15:0] a, b, c, d;

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        w_nn = 16'h8000; w_np = 16'h0; w_pn = 16'h0; w_pp = 16'h0;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_ovalid", 32'(out_valid), 32'd0);

        // single corner
        launch(16'h0, 16'h0, 16'h0, 16'h8000);
        repeat (16) step();
        chk("pp_not_yet", 32'(out_valid), 32'd0);
        step();
        chk("pp_valid17", 32'(out_valid), 32'd1);
        chk("pp_y", 32'(y), 32'h7FFF);
        chk("pp_div0", 32'(div0), 32'd0);
        drain();

        // two corners, -0.5 LSB
        launch(16'h4000, 16'h0, 16'h0, 16'h4000);
        wait_valid(lat);
        chk("two_lat", 32'(lat), 32'd17);
`ifdef DEFUZZ4_ROUND_EN
        chk("two_y", 32'(y), 32'hFFFF);
`else
        chk("two_y", 32'(y), 32'h0000);
`endif
        drain();

        // all zero weights
        launch(16'h0, 16'h0, 16'h0, 16'h0);
        step(); step();
        chk("zero_valid2", 32'(out_valid), 32'd1);
        chk("zero_y", 32'(y), 32'h0000);
        chk("zero_div0", 32'(div0), 32'd1);
        drain();

        // saturated weights
        launch(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_valid(lat);
        chk("max_lat", 32'(lat), 32'd17);
        chk("max_y", 32'(y), 32'h0000);
        chk("max_div0", 32'(div0), 32'd0);
        drain();

        // backpressure with a stray in_valid pulse
        launch(16'h0, 16'h8000, 16'h0, 16'h0);
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd17);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                w_nn = 16'h0; w_np = 16'h0; w_pn = 16'h0; w_pp = 16'h8000;
                in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
            chk("bp_ovalid", 32'(out_valid), 32'd1);
            chk("bp_y", 32'(y), 32'hC000);
            chk("bp_div0", 32'(div0), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        drain();
        repeat (20) step();
        chk("bp_no_capture", 32'(out_valid), 32'd0);

        // reset in the 8th DIV cycle
        launch(16'h1234, 16'h0, 16'h5678, 16'h0);
        repeat (8) step();
        chk("mid_ovalid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        step();
        chk("mrst_ovalid", 32'(out_valid), 32'd0);
        chk("mrst_y", 32'(y), 32'd0);
        chk("mrst_div0", 32'(div0), 32'd0);
        rst = 1'b0;
        step();
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        launch(16'h0, 16'h8000, 16'h0, 16'h0);
        wait_valid(lat);
        chk("fresh_lat", 32'(lat), 32'd17);
        chk("fresh_y", 32'(y), 32'hC000);
        drain();

        // randomized transactions
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            c = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            if (n % 10 == 9) begin
                a = 16'h0; b = 16'h0; c = 16'h0; d = 16'h0;
            end
            exp = model(a, b, c, d);
            launch(a, b, c, d);
            wait_valid(lat);
            if (exp[16]) chk("rnd_lat0", 32'(lat <= 2), 32'd1);
            else         chk("rnd_lat", 32'(lat), 32'd17);
            chk("rnd_y", 32'(y), 32'(exp[15:0]));
            chk("rnd_div0", 32'(div0), 32'(exp[16]));
            repeat ($urandom_range(0, 3)) step();
            chk("rnd_hold_y", 32'(y), 32'(exp[15:0]));
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
